// File: rtl/sum_window_avg_pkg.sv
// Shared widths and FSM encoding for the windowed-average block.
package sum_window_avg_pkg;
    localparam int DATA_W   = 7;
    localparam int WIN_LOG2 = 2;
    localparam int WIN_LEN  = 1 << WIN_LOG2;
    localparam int TOTAL_W  = DATA_W + WIN_LOG2;
    localparam int COUNT_W  = WIN_LOG2 + 1;

    typedef enum logic {
        FILL   = 1'b0,
        STEADY = 1'b1
    } state_e;
endpackage

// File: rtl/sum_window_avg_if.sv
// Input sample stream and output result stream of the averager.
// Handshake: a transfer happens on a rising edge where valid && ready; a
// producer holds valid and its payload stable until that transfer occurs.
interface sum_window_avg_if #(
    parameter int DATA_W = sum_window_avg_pkg::DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_sum;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_avg;
    logic              out_full;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_avg, out_full
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_avg, out_full
    );
endinterface

// File: rtl/sum_window_avg_window_shift_reg.sv
// Sample history for the averager: newest sample enters slot 0, the oldest
// (slot DEPTH-1) is exposed so the running total can subtract it on eviction.
module window_shift_reg #(
    parameter int DATA_W = sum_window_avg_pkg::DATA_W,
    parameter int DEPTH  = sum_window_avg_pkg::WIN_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] slot_last_o
);
    logic [DEPTH-1:0][DATA_W-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
        end else if (shift_en_i) begin
            slot_q <= {slot_q[DEPTH-2:0], din_i};
        end
    end

    assign slot_last_o = slot_q[DEPTH-1];
endmodule

// File: rtl/sum_window_avg.sv
// Running average of the last four accepted sums with a single registered
// output stage; FILL while the window is filling, STEADY once it is full.
module sum_window_avg #(
    parameter int DATA_W   = sum_window_avg_pkg::DATA_W,
    parameter int WIN_LOG2 = sum_window_avg_pkg::WIN_LOG2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    sum_window_avg_if.slave                      bus,
    output sum_window_avg_pkg::state_e           dbg_state_o,
    output logic [WIN_LOG2:0]                    dbg_count_o
);
    import sum_window_avg_pkg::state_e, sum_window_avg_pkg::FILL, sum_window_avg_pkg::STEADY;

    localparam int TOTAL_W = DATA_W + WIN_LOG2;
    localparam int COUNT_W = WIN_LOG2 + 1;
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(1 << WIN_LOG2);

    state_e              state_q, state_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [TOTAL_W-1:0]  total_q, total_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic                full_q, full_d;
    logic [DATA_W-1:0]   slot_last;
    logic                accept;
    logic                pop;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = valid_q && bus.out_ready;

    window_shift_reg #(
        .DATA_W (DATA_W),
        .DEPTH  (1 << WIN_LOG2)
    ) u_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .shift_en_i  (accept),
        .din_i       (bus.in_sum),
        .slot_last_o (slot_last)
    );

    // Modulo TOTAL_W arithmetic is exact here: the true total never exceeds 4*max.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        total_d = total_q;
        valid_d = valid_q;
        avg_d   = avg_q;
        full_d  = full_q;
        if (clr) begin
            state_d = FILL;
            count_d = '0;
            total_d = '0;
            valid_d = 1'b0;
            avg_d   = '0;
            full_d  = 1'b0;
        end else begin
            if (pop) valid_d = 1'b0;
            if (accept) begin
                unique case (state_q)
                    FILL: begin
                        total_d = total_q + TOTAL_W'(bus.in_sum);
                        count_d = count_q + 1'b1;
                        if (count_d == COUNT_FULL) state_d = STEADY;
                    end
                    STEADY: total_d = total_q + TOTAL_W'(bus.in_sum) - TOTAL_W'(slot_last);
                    default: ;
                endcase
                valid_d = 1'b1;
                avg_d   = total_d[TOTAL_W-1:WIN_LOG2];
                full_d  = (count_d == COUNT_FULL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
            total_q <= '0;
            valid_q <= 1'b0;
            avg_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            total_q <= total_d;
            valid_q <= valid_d;
            avg_q   <= avg_d;
            full_q  <= full_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_avg   = avg_q;
    assign bus.out_full  = full_q;
    assign dbg_state_o   = state_q;
    assign dbg_count_o   = count_q;
endmodule

// File: tb/tb_sum_window_avg.sv
// Bench for sum_window_avg: directed vector table, async-reset sequence and
// randomized traffic checked against a queue-based window model.
module tb_sum_window_avg;
    import sum_window_avg_pkg::*;

    logic clk;
    logic rst_n;
    logic clr;
    state_e dbg_state;
    logic [WIN_LOG2:0] dbg_count;

    sum_window_avg_if ifc ();

    sum_window_avg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .bus         (ifc),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: window as a queue, newest first; average from the plain sum.
    int   win_q[$];
    logic m_valid;
    int   m_avg;
    logic m_full;

    function automatic logic model_ready(input logic r);
        return !m_valid || r;
    endfunction

    task automatic model_reset();
        win_q.delete();
        m_valid = 1'b0;
        m_avg   = 0;
        m_full  = 1'b0;
    endtask

    task automatic model_step(input logic v, input int s, input logic r, input logic c);
        int sum;
        logic rdy;
        rdy = model_ready(r);
        if (c) begin
            model_reset();
        end else begin
            if (m_valid && r) m_valid = 1'b0;
            if (v && rdy) begin
                win_q.push_front(s);
                if (win_q.size() > 4) void'(win_q.pop_back());
                sum = 0;
                foreach (win_q[i]) sum += win_q[i];
                m_avg   = sum / 4;
                m_full  = (win_q.size() == 4);
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(ifc.out_valid), 32'(m_valid));
        check({tag, "_avg"},   32'(ifc.out_avg),   32'(m_avg));
        check({tag, "_full"},  32'(ifc.out_full),  32'(m_full));
        check({tag, "_count"}, 32'(dbg_count),     32'(win_q.size()));
        check({tag, "_state"}, 32'(dbg_state),     32'(win_q.size() == 4));
    endtask

    task automatic apply(input logic v, input logic [6:0] s, input logic r, input logic c);
        ifc.in_valid  = v;
        ifc.in_sum    = s;
        ifc.out_ready = r;
        clr           = c;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic run_cycle(input logic v, input logic [6:0] s, input logic r, input logic c,
                             input string tag);
        apply(v, s, r, c);
        #1;
        check({tag, "_rdy"}, 32'(ifc.in_ready), 32'(model_ready(r)));
        model_step(v, int'(s), r, c);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic       v;
        logic [6:0] s;
        logic       r;
        logic       c;
        logic       e_rdy;
        logic       e_valid;
        logic [6:0] e_avg;
        logic       e_full;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1'b1, 7'd8,   1'b1, 1'b0, 1'b1, 1'b1, 7'd2,   1'b0};
        tbl[1]  = '{1'b1, 7'd16,  1'b1, 1'b0, 1'b1, 1'b1, 7'd6,   1'b0};
        tbl[2]  = '{1'b1, 7'd24,  1'b1, 1'b0, 1'b1, 1'b1, 7'd12,  1'b0};
        tbl[3]  = '{1'b1, 7'd32,  1'b1, 1'b0, 1'b1, 1'b1, 7'd20,  1'b1};
        tbl[4]  = '{1'b1, 7'd40,  1'b1, 1'b0, 1'b1, 1'b1, 7'd28,  1'b1};
        tbl[5]  = '{1'b1, 7'd127, 1'b1, 1'b0, 1'b1, 1'b1, 7'd55,  1'b1};
        tbl[6]  = '{1'b1, 7'd127, 1'b1, 1'b0, 1'b1, 1'b1, 7'd81,  1'b1};
        tbl[7]  = '{1'b1, 7'd127, 1'b1, 1'b0, 1'b1, 1'b1, 7'd105, 1'b1};
        tbl[8]  = '{1'b1, 7'd127, 1'b1, 1'b0, 1'b1, 1'b1, 7'd127, 1'b1};
        tbl[9]  = '{1'b1, 7'd127, 1'b1, 1'b0, 1'b1, 1'b1, 7'd127, 1'b1};
        tbl[10] = '{1'b1, 7'd5,   1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 1'b1};
        tbl[11] = '{1'b1, 7'd5,   1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 1'b1};
        tbl[12] = '{1'b1, 7'd5,   1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 1'b1};
        tbl[13] = '{1'b1, 7'd5,   1'b1, 1'b0, 1'b1, 1'b1, 7'd96,  1'b1};
        tbl[14] = '{1'b1, 7'd9,   1'b1, 1'b1, 1'b1, 1'b0, 7'd0,   1'b0};
        tbl[15] = '{1'b1, 7'd4,   1'b1, 1'b0, 1'b1, 1'b1, 7'd1,   1'b0};

        rst_n = 1'b1;
        apply(1'b0, 7'd0, 1'b0, 1'b0);
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_avg",   32'(ifc.out_avg),   32'd0);
        check("rst_full",  32'(ifc.out_full),  32'd0);
        check("rst_rdy",   32'(ifc.in_ready),  32'd1);
        check("rst_count", 32'(dbg_count),     32'd0);
        check("rst_state", 32'(dbg_state),     32'(FILL));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table: fill, steady eviction, max values, backpressure, clr.
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].c);
            #1;
            check($sformatf("tbl%0d_rdy", i), 32'(ifc.in_ready), 32'(tbl[i].e_rdy));
            model_step(tbl[i].v, int'(tbl[i].s), tbl[i].r, tbl[i].c);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(ifc.out_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_avg", i),   32'(ifc.out_avg),   32'(tbl[i].e_avg));
            check($sformatf("tbl%0d_full", i),  32'(ifc.out_full),  32'(tbl[i].e_full));
            check_model($sformatf("tbl%0d_m", i));
        end
        check("clr_then_count", 32'(dbg_count), 32'd1);

        // Asynchronous reset while a result is pending.
        run_cycle(1'b1, 7'd60, 1'b0, 1'b0, "pre_rst");
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ifc.out_valid), 32'd0);
        check("arst_avg",   32'(ifc.out_avg),   32'd0);
        check("arst_full",  32'(ifc.out_full),  32'd0);
        check("arst_rdy",   32'(ifc.in_ready),  32'd1);
        check("arst_count", 32'(dbg_count),     32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_cycle(1'b0, 7'd0, 1'b1, 1'b0, "post_rst");
        run_cycle(1'b0, 7'd0, 1'b1, 1'b0, "post_rst2");

        // Randomized traffic against the window model.
        for (int i = 0; i < 400; i++) begin
            run_cycle($urandom_range(0, 3) != 0,
                      7'($urandom_range(0, 127)),
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 49) == 0,
                      "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sum_window_avg.md
SUM_WINDOW_AVG -- requirements
Module: sum_window_avg

Interface
REQ-001 Parameter DATA_W, default 7, width of the incoming sum samples and of the averaged output.
REQ-002 Parameter WIN_LOG2, default 2, log2 of the window length (window = 4 samples).
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 clr  input  1  synchronous clear of window, count and output stage.
REQ-006 in_valid  input  1  upstream adder sum is presented.
REQ-007 in_sum  input  DATA_W  registered sum from the upstream adder stage.
REQ-008 in_ready  output  1  block accepts in_sum this cycle.
REQ-009 out_valid  output  1  out_avg/out_full hold a result.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_avg  output  DATA_W  windowed average (running total >> WIN_LOG2).
REQ-012 out_full  output  1  result was computed over a full window.

Function
REQ-013 Accept occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready (combinational, single output stage, no skid buffer).
REQ-015 Window SHALL be a 4-entry shift buffer; on accept, the new sample enters slot 0, others shift, slot 3 is discarded.
REQ-016 Sample count SHALL increment on accept, saturate at 4, and never wrap.
REQ-017 Running total SHALL be DATA_W+WIN_LOG2 bits (9 bits), unsigned, no overflow possible.
REQ-018 On accept with count < 4: total_next = total + in_sum; with count == 4: total_next = total + in_sum - slot3.
REQ-019 Two-state FSM: FILL (count < 4) and STEADY (count == 4); FILL->STEADY on the 4th accept; STEADY->FILL only on clr or reset.
REQ-020 Latency SHALL be exactly 1 cycle: the result for an accept at edge N is visible on out_avg/out_valid after edge N.
REQ-021 out_avg SHALL equal total_next[DATA_W+WIN_LOG2-1:WIN_LOG2] (truncating divide by 4), also during FILL.
REQ-022 out_full SHALL be 1 iff count_next == 4.
REQ-023 out_valid set on accept; cleared on pop without accept; stays 1 when accept and pop coincide (new result replaces old).
REQ-024 While out_valid && !out_ready, out_avg/out_full SHALL remain stable and no sample is accepted.
REQ-025 clr SHALL have priority over accept: window, total and count zeroed, out_valid cleared, FSM to FILL; in_sum that cycle dropped.

Reset
REQ-026 rst_n low SHALL immediately clear window slots, total, count, out_valid, out_avg, out_full to 0 and set FSM to FILL.
REQ-027 in_ready SHALL read 1 during and after reset (follows REQ-014 with out_valid = 0).
REQ-028 Reset asserted mid-stream SHALL discard any pending result without emitting it.

Structure
REQ-029 Shared package SHALL hold DATA_W, WIN_LOG2, derived TOTAL_W and the FSM state enum (FILL, STEADY).
REQ-030 Window storage SHALL be a sub-module window_shift_reg (shift-enable, clear, exposes slot3), instantiated once.

Verification
REQ-031 Reset then feed 8, 16, 24, 32 with out_ready=1 -> out_avg 2, 6, 12, 20; out_full 0,0,0,1; out_valid each cycle after accept.
REQ-032 STEADY: window {32,24,16,8} then feed 40 -> total 112, out_avg 28, out_full 1 (sample 8 evicted).
REQ-033 Max values: feed 127 five times -> total saturates naturally at 508, out_avg 127, no wrap.
REQ-034 Backpressure: out_ready=0 after first result -> in_ready 0, out_avg held 3 cycles, second sample not accepted until out_ready=1.
REQ-035 clr asserted with in_valid=1 in STEADY -> next cycle out_valid 0, count 0; following sample 4 -> out_avg 1, out_full 0.
REQ-036 rst_n pulsed low mid-stream with out_valid=1 -> outputs 0 asynchronously, no stale result after release.
